// File: rtl/prio_code_decoder.sv
// Priority-code decoder: rebuilds a 16-bit request bitmap from a stream of 8-bit
// priority codes, one frame at a time, behind valid/ready handshakes.
module prio_code_decoder #(
    parameter logic [7:0] NONE_CODE = 8'hF0,
    parameter int         MAX_BEATS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_code,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [15:0] out_vec,
    output logic [4:0]  out_count,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam logic [4:0] MAX_CNT = 5'(MAX_BEATS);

    logic [1:0]  state;
    logic [15:0] acc;
    logic [4:0]  cnt;
    logic        err;

    logic [15:0] dec;
    logic        illegal;
    logic [4:0]  cnt_nxt;
    logic        hit_max;
    logic        commit;

    // Bit 15 is implied by every legal code; k < 15 adds the highest lower request.
    always_comb begin
        dec     = '0;
        illegal = 1'b0;
        if (in_code < 8'd15)
            dec = 16'h8000 | (16'd1 << in_code[3:0]);
        else if (in_code == NONE_CODE)
            dec = 16'h8000;
        else
            illegal = 1'b1;
    end

    assign in_ready = (state != HOLD);
    assign cnt_nxt  = cnt + 5'd1;
    assign hit_max  = (cnt_nxt == MAX_CNT);
    assign commit   = in_last | hit_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            out_vec   <= '0;
            out_count <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        acc <= acc | dec;
                        cnt <= cnt_nxt;
                        err <= err | illegal;
                        if (commit) begin
                            out_vec   <= acc | dec;
                            out_count <= cnt_nxt;
                            // A beat-limit commit without in_last marks a truncated frame.
                            out_err   <= err | illegal | (hit_max & ~in_last);
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        err       <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
